rvx_clock_reset_conditioner: RTL
================================

Name: rvx_clock_reset_conditioner

Overview:
Parametrised board-level clock/reset front end for RVX test and FPGA tops. It generalises the fixed divide-by-2 clock and single-flop reset register into three pieces:
- a programmable clock divider with an enable strobe;
- a synchronised, debounced reset button;
- a reset sequencer that stretches reset and reports its cause.

It sits between the board pins and the rvx_ocelot core. Its reset_n_out drives the core's reset_n.

Parameters:
CLOCK_DIVIDER, 2, input clocks per divided period; legal range 2..65535.
DEBOUNCE_CYCLES, 16, consecutive stable input clocks required to accept a button change; at least 1.
RESET_HOLD_CYCLES, 8, divided-clock periods reset stays asserted after its source clears; at least 1.
BUTTON_ACTIVE_HIGH, 1, 1 means the raw button reads 1 when pressed; 0 means active-low.
WATCHDOG_TIMEOUT, 1048576, divided periods without a kick before a watchdog reset; used only with RVX_CLKRST_WATCHDOG_EN.

Ports:
clock  input  1  board clock; all logic on posedge.
reset  input  1  synchronous, active-high global/power-on reset.
reset_button  input  1  raw, asynchronous, bouncing button.
divided_clock  output  1  divided clock for the core.
divided_clock_enable  output  1  one-cycle strobe in the last input cycle of each divided period.
reset_out  output  1  active-high conditioned reset; changes only on strobe cycles.
reset_n_out  output  1  inverse of reset_out.
button_state  output  1  debounced button, normalised so 1 = pressed.
reset_cause  output  2  00 power-on, 01 button, 10 watchdog; latched at reset entry.
watchdog_kick  input  1  present only with RVX_CLKRST_WATCHDOG_EN; 1-cycle pulse, sampled on strobe cycles.

Behaviour:
Values while reset=1:
- divider counter = 0, divided_clock = 1, divided_clock_enable = 0;
- sync flops = 0, button_state = 0, debounce counter = 0;
- FSM = HOLD with hold counter = 0;
- reset_out = 1, reset_cause = 00.

Divider:
- Counter runs 0..CLOCK_DIVIDER-1 and wraps to 0.
- divided_clock is 1 while counter < CLOCK_DIVIDER/2 (integer division), else 0. Odd ratios therefore have a shorter high phase.
- divided_clock_enable = 1 exactly when counter == CLOCK_DIVIDER-1.

Button path:
- Two-flop synchroniser, then polarity normalisation.
- Debounce counter clears whenever the synchronised value equals button_state.
- Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, button_state toggles and the counter clears.
- Latency from a clean edge to button_state is 2+DEBOUNCE_CYCLES clocks.
- Bounces shorter than DEBOUNCE_CYCLES never propagate.

Reset FSM (advances only on strobe cycles):
- IDLE, reset_out=0:
  - button_state=1 → ASSERT, cause 01.
  - Watchdog expiry → HOLD, cause 10, hold counter 0.
- ASSERT, reset_out=1:
  - button_state=0 → HOLD, hold counter 0.
- HOLD, reset_out=1:
  - Counts strobes.
  - On the strobe where hold counter == RESET_HOLD_CYCLES-1 → IDLE.
  - button_state=1 → ASSERT, cause 01 (a press restarts the sequence).

Timing and counters:
- reset_out is registered. It deasserts on the RESET_HOLD_CYCLES-th strobe after the source clears.
- Counter widths are $clog2 of (limit+1), with a minimum of 1 bit.
- No counter wraps silently; all counters saturate or clear as stated above.

Simultaneous events and mid-operation reset:
- Button and watchdog on the same strobe: the button wins, cause 01.
- Global reset mid-sequence aborts everything and forces the reset values. The cause reverts to 00.

Optional Feature:
RVX_CLKRST_WATCHDOG_EN.
When defined:
- The watchdog_kick port exists.
- A WATCHDOG_TIMEOUT counter increments on each strobe in IDLE.
- The counter clears on a kick in a strobe cycle and whenever reset_out=1.
- Reaching WATCHDOG_TIMEOUT-1 signals expiry.

When undefined:
- No port, no counter logic.
- reset_cause never takes the value 10.

Decomposition:
Package rvx_clkrst_pkg holds:
- reset_cause_t: CAUSE_POWER_ON=2'b00, CAUSE_BUTTON=2'b01, CAUSE_WATCHDOG=2'b10;
- state_t: IDLE, ASSERT, HOLD;
- the width helper function.

One sub-module, rvx_button_debouncer, contains the synchroniser, polarity normalisation and debounce counter, parametrised by DEBOUNCE_CYCLES and BUTTON_ACTIVE_HIGH.

Test Plan:
- DIV=2, HOLD=8, release global reset → reset_n_out rises on the 8th strobe (16 clocks); divided_clock toggles every clock; strobe every 2nd clock.
- DIV=5 → divided_clock high 2 clocks, low 3 clocks; strobe once per 5 clocks; no drift over 1000 periods.
- DEBOUNCE=16, button glitches 1-15 clocks wide → button_state stays 0. A clean press → button_state=1 exactly 18 clocks later, then reset_out=1 on the next strobe with cause 01.
- Press held, release, re-press after 3 of 8 hold strobes → FSM returns to ASSERT. reset_out never drops. The hold restarts at 8 on the final release.
- Global reset asserted mid-HOLD after a button reset → cause becomes 00, counters clear, full power-on sequence repeats.
- With RVX_CLKRST_WATCHDOG_EN and TIMEOUT=64: no kicks → reset_out=1 on the 64th strobe in IDLE with cause 10. A kick every 32 strobes → no reset. Press coinciding with expiry → cause 01.

Source files
------------

// File: rtl/rvx_clkrst_pkg.sv
// Shared types and sizing helper for the RVX clock/reset conditioner.
// The optional watchdog is enabled by defining RVX_CLKRST_WATCHDOG_EN.
package rvx_clkrst_pkg;

    typedef enum logic [1:0] {
        CAUSE_POWER_ON = 2'b00,
        CAUSE_BUTTON   = 2'b01,
        CAUSE_WATCHDOG = 2'b10
    } reset_cause_t;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLD
    } state_t;

    // Bits needed to hold values 0..limit, never less than one.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rvx_button_debouncer.sv
// Two-flop synchroniser, polarity normalisation and debounce filter for a raw
// board button; o_button_state is 1 while the button is considered pressed.
module rvx_button_debouncer
    import rvx_clkrst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_button_raw,
    output logic o_button_state
);

    localparam int                DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync0;
    logic            r_sync1;
    logic            r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_pressed;

    assign w_pressed      = BUTTON_ACTIVE_HIGH ? r_sync1 : ~r_sync1;
    assign o_button_state = r_state;

    // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_state  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync0 <= i_button_raw;
            r_sync1 <= r_sync0;
            if (w_pressed == r_state) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_state  <= ~r_state;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/rvx_clock_reset_conditioner.sv
// Board clock/reset front end: programmable divider, debounced reset button and
// a strobe-paced reset sequencer. Define RVX_CLKRST_WATCHDOG_EN for the watchdog.
module rvx_clock_reset_conditioner
    import rvx_clkrst_pkg::*;
#(
    parameter int CLOCK_DIVIDER      = 2,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int RESET_HOLD_CYCLES  = 8,
    parameter bit BUTTON_ACTIVE_HIGH = 1'b1,
    parameter int WATCHDOG_TIMEOUT   = 1048576
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reset_button,
`ifdef RVX_CLKRST_WATCHDOG_EN
    input  logic       watchdog_kick,
`endif
    output logic       divided_clock,
    output logic       divided_clock_enable,
    output logic       reset_out,
    output logic       reset_n_out,
    output logic       button_state,
    output logic [1:0] reset_cause
);

    localparam int                  DIV_W     = cnt_width(CLOCK_DIVIDER);
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [DIV_W-1:0]    DIV_HALF  = DIV_W'(CLOCK_DIVIDER / 2);
    localparam int                  HOLD_W    = cnt_width(RESET_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [DIV_W-1:0]  w_div_next;
    logic              r_div_clk;
    logic              r_strobe;
    logic              w_button_state;
    logic              w_wd_expire;
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_reset_out;
    reset_cause_t      r_cause;

    // Divider: outputs are registered from the next count so they stay glitch-free.
    assign w_div_next = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_div_clk <= 1'b1;
            r_strobe  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_div_clk <= (w_div_next < DIV_HALF);
            r_strobe  <= (w_div_next == DIV_LAST);
        end
    end

    rvx_button_debouncer #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .BUTTON_ACTIVE_HIGH(BUTTON_ACTIVE_HIGH)
    ) u_debouncer (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_button_raw  (reset_button),
        .o_button_state(w_button_state)
    );

`ifdef RVX_CLKRST_WATCHDOG_EN
    localparam int               WD_W    = cnt_width(WATCHDOG_TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WATCHDOG_TIMEOUT - 1);

    logic [WD_W-1:0] r_wd_cnt;

    // Only runs while the core is out of reset; a kick on a strobe always wins over expiry.
    always_ff @(posedge clock) begin
        if (reset || r_reset_out) begin
            r_wd_cnt <= '0;
        end else if (r_strobe) begin
            if (watchdog_kick) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != WD_LAST) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
        end
    end

    assign w_wd_expire = r_strobe && !watchdog_kick && (r_wd_cnt == WD_LAST);
`else
    // Watchdog compiled out; the timeout parameter stays in the interface for uniformity.
    assign w_wd_expire = 1'b0 && (WATCHDOG_TIMEOUT != 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= HOLD;
            r_hold_cnt  <= '0;
            r_reset_out <= 1'b1;
            r_cause     <= CAUSE_POWER_ON;
        end else if (r_strobe) begin
            unique case (r_state)
                IDLE: begin
                    if (w_button_state) begin
                        r_state     <= ASSERT;
                        r_reset_out <= 1'b1;
                        r_cause     <= CAUSE_BUTTON;
                    end else if (w_wd_expire) begin
                        r_state     <= HOLD;
                        r_hold_cnt  <= '0;
                        r_reset_out <= 1'b1;
                        r_cause     <= CAUSE_WATCHDOG;
                    end
                end
                ASSERT: begin
                    if (!w_button_state) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (w_button_state) begin
                        r_state <= ASSERT;
                        r_cause <= CAUSE_BUTTON;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= IDLE;
                        r_reset_out <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state     <= HOLD;
                    r_hold_cnt  <= '0;
                    r_reset_out <= 1'b1;
                end
            endcase
        end
    end

    assign divided_clock        = r_div_clk;
    assign divided_clock_enable = r_strobe;
    assign reset_out            = r_reset_out;
    assign reset_n_out          = ~r_reset_out;
    assign button_state         = w_button_state;
    assign reset_cause          = r_cause;

endmodule
